// File: rtl/calc_pkg.sv
// Shared constants for the UART calculator datapath: opcodes, scheduler
// state encoding, default widths and the watchdog error code.
package calc_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned RES_W_DEF  = 32;
  localparam int unsigned WDOG_W     = 8;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [31:0] TIMEOUT_RES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/calc_res_mux.sv
// Selects one unit's RES_W result slice by opcode; purely combinational so
// the TX formatter can reuse it.
module calc_res_mux
  import calc_pkg::*;
#(
  parameter int unsigned RES_W = RES_W_DEF
) (
  input  logic [1:0]         opcode_i,
  input  logic [4*RES_W-1:0] unit_res_i,
  output logic [RES_W-1:0]   res_c
);

  always_comb begin
    res_c = unit_res_i[0 +: RES_W];
    case (opcode_i)
      OP_ADD:  res_c = unit_res_i[0*RES_W +: RES_W];
      OP_SUB:  res_c = unit_res_i[1*RES_W +: RES_W];
      OP_MUL:  res_c = unit_res_i[2*RES_W +: RES_W];
      OP_DIV:  res_c = unit_res_i[3*RES_W +: RES_W];
      default: res_c = unit_res_i[0 +: RES_W];
    endcase
  end

endmodule

// File: rtl/calc_op_sched.sv
// Operation scheduler between the command parser and the add/sub/mul/div units.
// Define CALC_TIMEOUT_EN to add a WAIT-state watchdog (TIMEOUT_CYCLES).
module calc_op_sched
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned RES_W  = RES_W_DEF
`ifdef CALC_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               parser_done,
  output logic               parser_ready,
  input  logic [1:0]         opcode,
  input  logic [DATA_W-1:0]  src1,
  input  logic [DATA_W-1:0]  src2,
  output logic [3:0]         unit_start,
  output logic [DATA_W-1:0]  op_src1,
  output logic [DATA_W-1:0]  op_src2,
  input  logic [3:0]         unit_done,
  input  logic [4*RES_W-1:0] unit_res,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [RES_W-1:0]   calc_res,
  output logic               calc_err,
  output logic               busy
);

  sched_state_e       state_q;
  logic [1:0]         op_q;
  logic [RES_W-1:0]   sel_res_c;
`ifdef CALC_TIMEOUT_EN
  logic [WDOG_W-1:0]  wdog_q;
`endif

  calc_res_mux #(.RES_W(RES_W)) u_res_mux (
    .opcode_i   (op_q),
    .unit_res_i (unit_res),
    .res_c      (sel_res_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      op_src1      <= '0;
      op_src2      <= '0;
      unit_start   <= '0;
      parser_ready <= 1'b1;
      res_valid    <= 1'b0;
      calc_res     <= '0;
      calc_err     <= 1'b0;
      busy         <= 1'b0;
`ifdef CALC_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      unit_start <= '0;
      case (state_q)
        ST_IDLE: begin
          if (parser_done) begin
            op_q         <= opcode;
            op_src1      <= src1;
            op_src2      <= src2;
            parser_ready <= 1'b0;
            busy         <= 1'b1;
            state_q      <= ST_ISSUE;
            // Start is registered here so it lands exactly in the ISSUE cycle.
            if (!(opcode == OP_DIV && src2 == '0)) begin
              unit_start <= 4'b0001 << opcode;
            end
          end
        end
        ST_ISSUE: begin
          if (op_q == OP_DIV && op_src2 == '0) begin
            calc_res  <= '0;
            calc_err  <= 1'b1;
            res_valid <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            state_q <= ST_WAIT;
`ifdef CALC_TIMEOUT_EN
            wdog_q  <= '0;
`endif
          end
        end
        ST_WAIT: begin
          if (unit_done[op_q]) begin
            calc_res  <= sel_res_c;
            calc_err  <= 1'b0;
            res_valid <= 1'b1;
            state_q   <= ST_DONE;
`ifdef CALC_TIMEOUT_EN
          end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
            calc_res  <= RES_W'(TIMEOUT_RES);
            calc_err  <= 1'b1;
            res_valid <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
`endif
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid    <= 1'b0;
            parser_ready <= 1'b1;
            busy         <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_op_sched.sv
// Randomized self-checking bench for calc_op_sched against a transaction-level
// model of one operation (start pattern, result source, latency, hold).
module tb_calc_op_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         parser_done;
  logic         parser_ready;
  logic [1:0]   opcode;
  logic [15:0]  src1;
  logic [15:0]  src2;
  logic [3:0]   unit_start;
  logic [15:0]  op_src1;
  logic [15:0]  op_src2;
  logic [3:0]   unit_done;
  logic [127:0] unit_res;
  logic         res_valid;
  logic         res_ready;
  logic [31:0]  calc_res;
  logic         calc_err;
  logic         busy;

  logic [31:0]  unit_val [4];
  int           errors = 0;
  int           checks = 0;

  always #5 clk = ~clk;

  always_comb unit_res = {unit_val[3], unit_val[2], unit_val[1], unit_val[0]};

  calc_op_sched #(
    .DATA_W(16),
    .RES_W (32)
`ifdef CALC_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .parser_done  (parser_done),
    .parser_ready (parser_ready),
    .opcode       (opcode),
    .src1         (src1),
    .src2         (src2),
    .unit_start   (unit_start),
    .op_src1      (op_src1),
    .op_src2      (op_src2),
    .unit_done    (unit_done),
    .unit_res     (unit_res),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .calc_res     (calc_res),
    .calc_err     (calc_err),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One complete operation; the expected result comes from the opcode's slice,
  // or 0/err for divide-by-zero. d = WAIT cycles before the right done.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] r, input int d, input bit wrong,
                        input bit early, input int bp);
    logic        div0;
    logic [31:0] exp_res;
    logic [31:0] exp_err;
    logic [1:0]  w;
    for (int k = 0; k < 4; k++) unit_val[k] = $urandom;
    unit_val[op] = r;
    div0    = (op == 2'd3) && (b == 16'd0);
    exp_res = div0 ? 32'd0 : r;
    exp_err = div0 ? 32'd1 : 32'd0;

    check_eq("ready_idle", 32'(parser_ready), 32'd1);
    opcode = op; src1 = a; src2 = b; parser_done = 1'b1;
    cyc();
    parser_done = 1'b0;
    opcode = 2'($urandom); src1 = 16'($urandom); src2 = 16'($urandom);
    check_eq("start", 32'(unit_start), div0 ? 32'd0 : (32'd1 << op));
    check_eq("busy", 32'(busy), 32'd1);
    check_eq("ready_busy", 32'(parser_ready), 32'd0);
    check_eq("op_src1", 32'(op_src1), 32'(a));
    check_eq("op_src2", 32'(op_src2), 32'(b));

    if (div0) begin
      cyc();
    end else begin
      if (early) unit_done = 4'b0001 << op;
      cyc();
      unit_done = 4'b0000;
      check_eq("start_pulse", 32'(unit_start), 32'd0);
      check_eq("wait_valid", 32'(res_valid), 32'd0);
      for (int k = 0; k < d; k++) begin
        w = op + 2'($urandom_range(1, 3));
        if (wrong) unit_done = 4'b0001 << w;
        cyc();
        unit_done = 4'b0000;
        check_eq("wait_valid", 32'(res_valid), 32'd0);
        check_eq("hold_src1", 32'(op_src1), 32'(a));
      end
      unit_done = 4'b0001 << op;
      cyc();
      unit_done = 4'b0000;
    end
    check_eq("res_valid", 32'(res_valid), 32'd1);
    check_eq("calc_res", calc_res, exp_res);
    check_eq("calc_err", 32'(calc_err), exp_err);

    for (int k = 0; k < bp; k++) begin
      res_ready = 1'b0;
      parser_done = 1'($urandom);
      cyc();
      check_eq("bp_valid", 32'(res_valid), 32'd1);
      check_eq("bp_res", calc_res, exp_res);
      check_eq("bp_err", 32'(calc_err), exp_err);
      check_eq("bp_ready", 32'(parser_ready), 32'd0);
    end
    parser_done = 1'b0;
    res_ready = 1'b1;
    cyc();
    check_eq("hs_valid", 32'(res_valid), 32'd0);
    check_eq("hs_ready", 32'(parser_ready), 32'd1);
    check_eq("hs_busy", 32'(busy), 32'd0);
    cyc();
    check_eq("no_queue_busy", 32'(busy), 32'd0);
    check_eq("no_queue_start", 32'(unit_start), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1; parser_done = 1'b0; opcode = '0; src1 = '0; src2 = '0;
    unit_done = '0; res_ready = 1'b1;
    for (int k = 0; k < 4; k++) unit_val[k] = '0;
    #2;
    check_eq("rst_ready", 32'(parser_ready), 32'd1);
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_start", 32'(unit_start), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_res", calc_res, 32'd0);
    check_eq("rst_err", 32'(calc_err), 32'd0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // add 9+1, done two cycles after start
    run_op(2'd0, 16'd9, 16'd1, 32'd10, 1, 1'b0, 1'b0, 0);
    // divide by zero
    run_op(2'd3, 16'd6, 16'd0, 32'h1234_5678, 0, 1'b0, 1'b0, 0);
    // mul 6*2 with five cycles of back-pressure
    run_op(2'd2, 16'd6, 16'd2, 32'd12, 1, 1'b0, 1'b0, 5);
    // sub with stray dones from other units
    run_op(2'd1, 16'd7, 16'd3, 32'd4, 3, 1'b1, 1'b1, 0);

    // reset in WAIT, then a late sub done must be ignored
    opcode = 2'd1; src1 = 16'd5; src2 = 16'd2; parser_done = 1'b1;
    cyc();
    parser_done = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    #1;
    check_eq("rstw_state", 32'(busy), 32'd0);
    check_eq("rstw_ready", 32'(parser_ready), 32'd1);
    check_eq("rstw_valid", 32'(res_valid), 32'd0);
    cyc();
    rst = 1'b0;
    unit_done = 4'b0010;
    cyc();
    unit_done = 4'b0000;
    check_eq("rstw_late_valid", 32'(res_valid), 32'd0);
    check_eq("rstw_late_busy", 32'(busy), 32'd0);

    // reset in ISSUE clears the start pulse at once
    opcode = 2'd2; src1 = 16'd3; src2 = 16'd3; parser_done = 1'b1;
    cyc();
    parser_done = 1'b0;
    check_eq("rsti_start_pre", 32'(unit_start), 32'd4);
    #2 rst = 1'b1;
    #1;
    check_eq("rsti_start", 32'(unit_start), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();

`ifdef CALC_TIMEOUT_EN
    // unit never answers: watchdog ends the operation after 4 WAIT cycles
    opcode = 2'd2; src1 = 16'd1; src2 = 16'd1; parser_done = 1'b1;
    cyc();
    parser_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_eq("to_wait", 32'(res_valid), 32'd0);
    end
    cyc();
    check_eq("to_valid", 32'(res_valid), 32'd1);
    check_eq("to_res", calc_res, 32'hFFFF_FFFF);
    check_eq("to_err", 32'(calc_err), 32'd1);
    cyc();
    check_eq("to_idle", 32'(parser_ready), 32'd1);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [15:0] b;
      op = 2'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      run_op(op, 16'($urandom), b, $urandom, $urandom_range(0, 4),
             1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_op_sched.md
Name: calc_op_sched

Overview:
- Operation scheduler for the UART calculator datapath; sits between the command parser and the four arithmetic units (add, sub, mul, div).
- Accepts one parsed operation (opcode plus two 16-bit operands) and issues a one-cycle start to the selected unit.
- Waits for that unit's done, captures its 32-bit result, and presents it to the UART TX formatter with a valid/ready handshake.
- Guards divide-by-zero; optionally guards against a hung unit with a watchdog.

Parameters:
- DATA_W, 16, operand width.
- RES_W, 32, result width.
- TIMEOUT_CYCLES, 255, watchdog limit in WAIT (used only with CALC_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- parser_done  in  1  operation valid from the parser.
- parser_ready  out  1  scheduler can accept an operation.
- opcode  in  2  operation select: 0 add, 1 sub, 2 mul, 3 div.
- src1  in  DATA_W  operand 1.
- src2  in  DATA_W  operand 2.
- unit_start  out  4  one-hot start pulse, bit index = opcode.
- op_src1  out  DATA_W  registered operand 1 driven to the units.
- op_src2  out  DATA_W  registered operand 2 driven to the units.
- unit_done  in  4  per-unit done, bit index = opcode.
- unit_res  in  4*RES_W  unit results; unit k occupies [k*RES_W +: RES_W].
- res_valid  out  1  result available.
- res_ready  in  1  TX formatter accepts the result.
- calc_res  out  RES_W  result.
- calc_err  out  1  error qualifier, valid while res_valid=1.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE. All outputs 0 except parser_ready=1.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - parser_ready=1.
  - On parser_done=1: latch opcode/src1/src2 into op registers and go to ISSUE.
  - parser_ready is 0 in every other state; parser_done outside IDLE is ignored, not queued.
- ISSUE (exactly one cycle):
  - Divide by zero (opcode=3 and op_src2=0): no start pulse; calc_res=0, calc_err=1; go to DONE.
  - Otherwise: unit_start[opcode]=1 for this cycle only; go to WAIT.
- WAIT:
  - op_src1/op_src2 held stable.
  - On unit_done[opcode]=1: capture that unit's slice of unit_res into calc_res, set calc_err=0, go to DONE.
  - Done bits of non-selected units are ignored.
- DONE:
  - res_valid=1; calc_res and calc_err held.
  - When res_valid and res_ready are both 1: drop res_valid and go to IDLE. The next operation can be accepted on the following cycle.
- Latency:
  - parser_done sampled in cycle N → unit_start in N+1.
  - unit_done in cycle M → res_valid in M+1.
  - Divide-by-zero → res_valid in N+2.
- Back-pressure: res_ready=0 holds DONE indefinitely with outputs stable.
- unit_done already high in the ISSUE cycle is not sampled; only WAIT samples unit_done.
- rst asserted in any state aborts the operation:
  - unit_start clears immediately.
  - The in-flight unit result is discarded.
- No arithmetic is performed here; results pass through at full RES_W width, with no truncation or sign handling.

Optional Feature:
- Macro: CALC_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counter clears on entry to WAIT and increments each cycle spent in WAIT.
  - When the count reaches TIMEOUT_CYCLES with no done, go to DONE with calc_res=32'hFFFF_FFFF and calc_err=1.
  - A done arriving in the same cycle as the timeout wins: normal result, calc_err=0.
- Undefined: no counter; WAIT is left only on done or reset.

Decomposition:
- Package calc_pkg holds:
  - Opcode localparams OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3.
  - State encodings.
  - DATA_W and RES_W defaults.
  - The timeout error code 32'hFFFF_FFFF.
- One sub-module, calc_res_mux: selects the RES_W slice of unit_res by opcode. Combinational and reused by the TX formatter.
- The FSM, operand registers and watchdog stay in calc_op_sched.

Test Plan:
- Add: opcode=0, src1=9, src2=1; add unit asserts done 2 cycles after start with result 10.
  - Required: unit_start=4'b0001 for one cycle; calc_res=32'd10; calc_err=0; res_valid exactly 1 cycle after done.
- Divide by zero: opcode=3, src1=6, src2=0.
  - Required: no unit_start pulse; res_valid 2 cycles after parser_done; calc_res=0; calc_err=1.
- Back-pressure: mul 6*2 with res_ready=0 for 5 cycles.
  - Required: res_valid and calc_res=12 held for all 5 cycles; parser_done pulsed during the hold is ignored; IDLE follows the handshake.
- Wrong-unit done: sub issued while the add unit's done fires first.
  - Required: the add done is ignored; the result is taken from the sub slice.
- Reset mid-op: rst asserted in WAIT.
  - Required: immediate IDLE, res_valid=0, parser_ready=1; a later sub done is ignored.
- CALC_TIMEOUT_EN, TIMEOUT_CYCLES=4: unit never asserts done.
  - Required: calc_res=32'hFFFF_FFFF and calc_err=1 after 4 WAIT cycles.
